// File: rtl/fc_classifier.sv
// Fully-connected classifier: multiplies a latched vector of pooled pixels
// against a register-file weight matrix one product per cycle, then reports
// the class with the highest saturated, shifted score.
module fc_classifier #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int SHIFT = 4,
  localparam int NW   = N_IN * N_OUT,
  localparam int WAW  = (NW > 1) ? $clog2(NW) : 1,
  localparam int CW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_we,
  input  logic [WAW-1:0]       w_addr,
  input  logic [WW-1:0]        w_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*DW-1:0]   in_pixels,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_class,
  output logic [DW-1:0]        out_score
);

  localparam int PW  = DW + WW + 1;
  localparam int AW  = PW + $clog2(N_IN);
  localparam int PXW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic signed [AW-1:0] SMAX = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  localparam logic [WAW:0]         WLIM = (WAW + 1)'(NW);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                  state_reg, state_next;
  logic signed [WW-1:0]    weight_reg [NW];
  logic [N_IN*DW-1:0]      pixels_reg;
  logic [DW-1:0]           pix_arr [N_IN];
  logic [PXW-1:0]          pix_reg;
  logic [CW-1:0]           cls_reg;
  logic signed [AW-1:0]    acc_reg;
  logic signed [DW-1:0]    best_score_reg;
  logic [CW-1:0]           best_class_reg;

  logic                    w_ok;
  logic [WAW-1:0]          widx;
  logic signed [WW-1:0]    cur_w;
  logic signed [PW-1:0]    pix_s, w_s, product;
  logic signed [AW-1:0]    sum, shifted;
  logic signed [DW-1:0]    score;
  logic                    last_pix, last_cls, better;

  // Unpack the latched pixel word so the MAC can index it by pixel counter
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
    assign pix_arr[gi] = pixels_reg[gi*DW +: DW];
  end

  // Weights are writable only while idle, and only inside the matrix
  assign w_ok = w_we && (state_reg == IDLE) && ({1'b0, w_addr} < WLIM);

  // Current product, running sum, and saturated score for the class in flight
  always_comb begin
    widx     = WAW'(int'(cls_reg) * N_IN + int'(pix_reg));
    cur_w    = weight_reg[widx];
    pix_s    = signed'({{(PW-DW){1'b0}}, pix_arr[pix_reg]});
    w_s      = PW'(cur_w);
    product  = pix_s * w_s;
    sum      = acc_reg + AW'(product);
    shifted  = sum >>> SHIFT;
    if (shifted > SMAX)
      score = DW'(SMAX);
    else if (shifted < SMIN)
      score = DW'(SMIN);
    else
      score = DW'(shifted);
    better   = score > best_score_reg;
    last_pix = pix_reg == PXW'(N_IN - 1);
    last_cls = cls_reg == CW'(N_OUT - 1);
  end

  // Weight register file, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) weight_reg[i] <= '0;
    end else if (w_ok) begin
      weight_reg[w_addr] <= w_data;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)             state_next = MAC;
      MAC:     if (last_pix && last_cls) state_next = OUT;
      OUT:     if (out_ready)            state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == OUT);
  end

  assign out_class = best_class_reg;
  assign out_score = best_score_reg;

  // Datapath: latch vector, step counters, accumulate, track best class
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixels_reg     <= '0;
      pix_reg        <= '0;
      cls_reg        <= '0;
      acc_reg        <= '0;
      best_score_reg <= '0;
      best_class_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            pixels_reg     <= in_pixels;
            pix_reg        <= '0;
            cls_reg        <= '0;
            acc_reg        <= '0;
            best_score_reg <= DW'(SMIN);
            best_class_reg <= '0;
          end
        end
        MAC: begin
          if (last_pix) begin
            acc_reg <= '0;
            pix_reg <= '0;
            cls_reg <= cls_reg + 1'b1;
            if (better) begin
              best_score_reg <= score;
              best_class_reg <= cls_reg;
            end
          end else begin
            acc_reg <= sum;
            pix_reg <= pix_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_classifier.sv
// Directed-vector bench for fc_classifier with a queue-based scoreboard:
// the driver pushes expected results, the monitor pops on each handshake.
module tb_fc_classifier;

  logic        clk = 0;
  logic        rst_n;
  logic        w_we;
  logic [3:0]  w_addr;
  logic [7:0]  w_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pixels;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_class;
  logic [7:0]  out_score;

  fc_classifier dut (
    .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixels(in_pixels),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_score(out_score)
  );

  always #5 clk = ~clk;

  typedef struct { int cls; int score; } exp_t;
  exp_t exp_q[$];
  int   acc_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic fail_now(string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endtask

  // Monitor: latency, hold stability while stalled, and scoreboard compare
  int   n = 0;
  bit   seen = 0;
  int   hc, hs;
  always @(negedge clk) begin
    n++;
    if (!rst_n) begin
      acc_q.delete();
      seen = 0;
    end else begin
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          hc = int'(out_class);
          hs = int'($signed(out_score));
          if (acc_q.size() == 0) fail_now("unexpected_out");
          else check("latency", n - acc_q.pop_front(), 16);
        end else begin
          check("hold_class", int'(out_class), hc);
          check("hold_score", int'($signed(out_score)), hs);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_result");
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("class", int'(out_class), e.cls);
            check("score", int'($signed(out_score)), e.score);
          end
          seen = 0;
        end
      end
      // acceptance happens at the next rising edge; stamp the negedge after it
      if (in_valid && in_ready) acc_q.push_back(n + 1);
    end
  end

  // All driver tasks start and end at posedge+1
  task automatic wr(input int addr, input int data);
    w_we = 1; w_addr = 4'(addr); w_data = 8'(data);
    @(posedge clk); #1;
    w_we = 0;
  endtask

  task automatic wr_all(input int data);
    for (int i = 0; i < 16; i++) wr(i, data);
  endtask

  task automatic send(input logic [31:0] pix, input bit push, input int cls, input int sc);
    int k;
    exp_t e;
    k = 0;
    while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
    if (!in_ready) fail_now("wait_ready");
    if (push) begin e.cls = cls; e.score = sc; exp_q.push_back(e); end
    in_pixels = pix;
    in_valid  = 1;
    @(posedge clk); #1;
    in_valid  = 0;
    w_we      = 0;
    in_pixels = $urandom;   // must not disturb the vector in flight
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
    if (!in_ready) fail_now("wait_idle");
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; w_we = 0; w_addr = 0; w_data = 0;
    in_valid = 0; in_pixels = 0; out_ready = 1;
    repeat (3) @(posedge clk); #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready",  int'(in_ready), 1);
    check("rst_out_class", int'(out_class), 0);
    check("rst_out_score", int'(out_score), 0);
    rst_n = 1;
    @(posedge clk); #1;

    // zero weights
    send({8'd4, 8'd3, 8'd2, 8'd1}, 1, 0, 0);
    wait_idle();

    // class 2 = 16s; last write coincides with acceptance
    wr(8, 16); wr(9, 16); wr(10, 16);
    w_we = 1; w_addr = 4'd11; w_data = 8'd16;
    send({8'd4, 8'd3, 8'd2, 8'd1}, 1, 2, 10);
    wait_idle();

    // positive saturation, tie -> class 0
    wr_all(127);
    send(32'hFFFF_FFFF, 1, 0, 127);
    wait_idle();

    // negative saturation
    wr_all(-128);
    send(32'hFFFF_FFFF, 1, 0, -128);
    wait_idle();

    // mixed signs, tie between classes 1 and 3 -> 1
    wr_all(0);
    for (int i = 0; i < 4; i++) begin
      wr(i, -1);
      wr(4 + i, i + 1);
      wr(12 + i, i + 1);
    end
    send({8'd64, 8'd48, 8'd32, 8'd16}, 1, 1, 30);
    wait_idle();

    // last class wins with saturation
    wr(12, 100);
    send({8'd64, 8'd48, 8'd32, 8'd16}, 1, 3, 127);
    wait_idle();

    // stall in OUT: held outputs, no accept, write dropped
    out_ready = 0;
    send({8'd64, 8'd48, 8'd32, 8'd16}, 1, 3, 127);
    begin
      int k;
      k = 0;
      while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
      if (!out_valid) fail_now("wait_out_valid");
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; w_we = 1; w_addr = 4'd0; w_data = 8'd77;
      @(posedge clk); #1;
      check("stall_in_ready", int'(in_ready), 0);
    end
    check("stall_out_valid", int'(out_valid), 1);
    in_valid = 0; w_we = 0;
    out_ready = 1;
    wait_idle();
    // weight 0 still -1: class 3 wins rather than class 0
    send({8'd0, 8'd0, 8'd0, 8'd255}, 1, 3, 127);
    wait_idle();

    // reset during the 7th MAC cycle
    send({8'd64, 8'd48, 8'd32, 8'd16}, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready",  int'(in_ready), 1);
    repeat (3) @(posedge clk); #1;
    rst_n = 1;
    repeat (30) @(posedge clk); #1;
    check("abort_idle", int'(in_ready), 1);
    // weights cleared by reset
    send({8'd0, 8'd0, 8'd0, 8'd255}, 1, 0, 0);
    wait_idle();

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fc_classifier.md
FC_CLASSIFIER -- requirements
Module: fc_classifier

Interface
REQ-001 Parameter N_IN, default 4, number of pooled pixels per input vector.
REQ-002 Parameter N_OUT, default 4, number of output classes/neurons (X, 0, /, \).
REQ-003 Parameter DW, default 8, pixel width (unsigned) and score width (signed).
REQ-004 Parameter WW, default 8, weight width (signed two's complement).
REQ-005 Parameter SHIFT, default 4, arithmetic right shift applied to each accumulator before saturation.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 w_we  in  1  weight write enable.
REQ-009 w_addr  in  clog2(N_IN*N_OUT)  weight index = class*N_IN + pixel.
REQ-010 w_data  in  WW  signed weight value.
REQ-011 in_valid  in  1  input vector valid.
REQ-012 in_ready  out  1  block can accept a vector.
REQ-013 in_pixels  in  N_IN*DW  pooled pixels, pixel i at bits [i*DW +: DW], unsigned.
REQ-014 out_valid  out  1  classification result valid.
REQ-015 out_ready  in  1  downstream accepts result.
REQ-016 out_class  out  clog2(N_OUT)  index of winning class.
REQ-017 out_score  out  DW  signed saturated score of winning class.

Function
REQ-018 States IDLE, MAC, OUT; in_ready SHALL equal (state==IDLE).
REQ-019 IDLE: on in_valid&&in_ready, in_pixels SHALL be latched, class/pixel counters and accumulator cleared, best score set to most negative value, best class to 0, state -> MAC.
REQ-020 MAC: one product pixel[i]*weight[c][i] per cycle, pixel index inner loop, class index outer loop; N_IN*N_OUT cycles total.
REQ-021 Product width DW+WW+1 signed (pixel zero-extended); accumulator width DW+WW+1+clog2(N_IN); no internal overflow possible.
REQ-022 On the cycle adding the last product of class c, score = (acc+product) >>> SHIFT, saturated to [-2^(DW-1), 2^(DW-1)-1], compared to best in the same cycle; accumulator cleared for next class.
REQ-023 Best updated only if score is strictly greater; ties keep lowest class index.
REQ-024 After the last class, state -> OUT; out_valid SHALL rise exactly N_IN*N_OUT cycles after the acceptance edge.
REQ-025 OUT: out_valid, out_class, out_score held stable until out_valid&&out_ready; then state -> IDLE, out_valid low next cycle.
REQ-026 No new vector accepted in MAC or OUT; in_pixels changes during MAC SHALL NOT affect the result.
REQ-027 Weight write takes effect at the clock edge only in IDLE; writes in MAC/OUT and writes with w_addr >= N_IN*N_OUT SHALL be dropped.
REQ-028 Simultaneous weight write and vector acceptance in IDLE: write SHALL complete and be used for that vector.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, in_ready 1, out_valid 0, out_class 0, out_score 0, all weights 0, counters and accumulator 0.
REQ-030 Reset mid-MAC or mid-OUT SHALL abandon the operation; no result is emitted after release.

Verification
REQ-031 Reset: rst_n low -> out_valid 0, in_ready 1, out_class 0, out_score 0; then vector {1,2,3,4} with zero weights -> out_class 0, out_score 0.
REQ-032 Weights class 2 = {16,16,16,16}, others 0; pixels {1,2,3,4} -> out_valid 16 cycles after accept, out_class 2, out_score 10.
REQ-033 All weights 127, pixels all 255 -> acc 129540, shifted 8096 -> out_score 127, out_class 0 (tie).
REQ-034 All weights -128, pixels all 255 -> shifted -8160 -> out_score -128, out_class 0.
REQ-035 out_ready low 5 cycles in OUT, in_valid high, weight write to addr 0 -> outputs stable, in_ready 0, no accept, weight 0 unchanged after read-back test.
REQ-036 rst_n low at 7th MAC cycle -> out_valid 0 and in_ready 1 immediately, weights read back as 0, no out_valid after release.
